// File: rtl/dds_update_scheduler.sv
// dds_update_scheduler
// Sequences frequency / phase / amplitude updates from the PID output decode
// onto a single DDS serial controller. Each update type has a one-deep
// coalescing slot (newest value wins). Slots are granted round-robin, and
// only one command is outstanding at a time: after the valid/ready handshake
// the scheduler waits for the controller's write-done pulse.
//
// Optional feature (macro DDS_SCHED_TIMEOUT_EN): a write-done watchdog.
// After TIMEOUT_CYC cycles in WAIT_DONE without wr_done_in, the scheduler
// returns to IDLE and pulses timeout_out. The timed-out command is dropped.
// Without the macro, WAIT_DONE waits indefinitely and timeout_out is 0.
//
// Ports:
//   clk_in, rst_in             clock, asynchronous active-low reset
//   freq_dv_in / freq_in       frequency update strobe / word
//   phase_dv_in / phase_in     phase update strobe / word
//   amp_dv_in / amp_in         amplitude update strobe / word
//   cmd_valid_out/cmd_ready_in command handshake to dds_controller
//   cmd_type_out               0 = freq, 1 = phase, 2 = amp
//   cmd_data_out               payload, zero-extended to W_CMD
//   wr_done_in                 one-cycle pulse: serial write + IO update done
//   busy_out                   FSM not in IDLE
//   pending_out                slot flags {amp, phase, freq}
//   coalesce_cnt_out           saturating count of overwritten pending updates
//   timeout_out                one-cycle watchdog pulse
module dds_update_scheduler #(
  parameter int W_FREQ      = 48,
  parameter int W_PHASE     = 14,
  parameter int W_AMP       = 10,
  parameter int W_CMD       = 48,
  parameter int W_CNT       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               freq_dv_in,
  input  logic [W_FREQ-1:0]  freq_in,
  input  logic               phase_dv_in,
  input  logic [W_PHASE-1:0] phase_in,
  input  logic               amp_dv_in,
  input  logic [W_AMP-1:0]   amp_in,
  output logic               cmd_valid_out,
  output logic [1:0]         cmd_type_out,
  output logic [W_CMD-1:0]   cmd_data_out,
  input  logic               cmd_ready_in,
  input  logic               wr_done_in,
  output logic               busy_out,
  output logic [2:0]         pending_out,
  output logic [W_CNT-1:0]   coalesce_cnt_out,
  output logic               timeout_out
);

  localparam int NUM_SLOTS = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NUM_SLOTS-1:0]            strobe;
  logic [NUM_SLOTS-1:0]            pend_q;
  logic [NUM_SLOTS-1:0]            grant_vec;
  logic [NUM_SLOTS-1:0]            ovw;
  logic [NUM_SLOTS-1:0][W_CMD-1:0] din;
  logic [NUM_SLOTS-1:0][W_CMD-1:0] slot_q;

  logic [1:0]       last_q;
  logic [1:0]       gnt_idx;
  logic             any_pend;
  logic             grant;
  logic [1:0]       cmd_type_q;
  logic [W_CMD-1:0] cmd_data_q;
  logic [W_CNT-1:0] cnt_q;
  logic [1:0]       ovw_sum;
  logic [W_CNT+1:0] cnt_sum;
  logic             to_expire;

  // Slot index k positions after base, modulo 3.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NUM_SLOTS;
    return s[1:0];
  endfunction

  assign strobe = {amp_dv_in, phase_dv_in, freq_dv_in};
  assign din[0] = W_CMD'(freq_in);
  assign din[1] = W_CMD'(phase_in);
  assign din[2] = W_CMD'(amp_in);

  // ---------------------------------------------------------------------
  // Round-robin pick: scan from the type after the last grant. Walk the
  // order from lowest to highest priority so the highest one wins.
  // ---------------------------------------------------------------------
  always_comb begin
    gnt_idx  = 2'd0;
    any_pend = 1'b0;
    for (int k = NUM_SLOTS; k >= 1; k--) begin
      if (pend_q[rr_idx(last_q, k)]) begin
        gnt_idx  = rr_idx(last_q, k);
        any_pend = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_pend) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // wr_done_in is deliberately not looked at here
        if (cmd_ready_in) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // completion wins over a same-cycle watchdog expiry
        if (wr_done_in || to_expire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_vec = grant ? (3'b001 << gnt_idx) : 3'b000;

  // ---------------------------------------------------------------------
  // Coalescing slots. A strobe always loads the slot and sets pending; a
  // strobe in the grant cycle of the same slot is a fresh update, not an
  // overwrite, since the old value is leaving on the command bus.
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    logic             pend_r;
    logic [W_CMD-1:0] data_r;

    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        pend_r <= 1'b0;
        data_r <= '0;
      end else if (strobe[i]) begin
        pend_r <= 1'b1;
        data_r <= din[i];
      end else if (grant_vec[i]) begin
        pend_r <= 1'b0;
      end
    end

    assign pend_q[i] = pend_r;
    assign slot_q[i] = data_r;
    assign ovw[i]    = strobe[i] & pend_r & ~grant_vec[i];
  end

  // ---------------------------------------------------------------------
  // Coalesce counter: up to +3 per cycle, saturating. Two guard bits keep
  // the sum exact even for very narrow counters.
  // ---------------------------------------------------------------------
  assign ovw_sum = 2'(ovw[0]) + 2'(ovw[1]) + 2'(ovw[2]);
  assign cnt_sum = {2'b00, cnt_q} + {W_CNT'(0), ovw_sum};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q <= '0;
    end else if (|cnt_sum[W_CNT+1:W_CNT]) begin
      cnt_q <= '1;
    end else begin
      cnt_q <= cnt_sum[W_CNT-1:0];
    end
  end

  // ---------------------------------------------------------------------
  // Command register: loaded at grant, held stable through ISSUE.
  // last_q resets to amp so the first search starts at freq.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cmd_type_q <= 2'd0;
      cmd_data_q <= '0;
      last_q     <= 2'd2;
    end else if (grant) begin
      cmd_type_q <= gnt_idx;
      cmd_data_q <= slot_q[gnt_idx];
      last_q     <= gnt_idx;
    end
  end

  // ---------------------------------------------------------------------
  // Write-done watchdog
  // ---------------------------------------------------------------------
`ifdef DDS_SCHED_TIMEOUT_EN
  localparam int W_TO = $clog2(TIMEOUT_CYC + 1);

  logic [W_TO-1:0] to_cnt_q;
  logic            to_pulse_q;

  // Counter is held at zero outside WAIT_DONE, so it starts at 0 on entry.
  assign to_expire = (state_q == WAIT_DONE) && !wr_done_in &&
                     (to_cnt_q == W_TO'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      to_cnt_q   <= '0;
      to_pulse_q <= 1'b0;
    end else begin
      to_pulse_q <= to_expire;
      if (state_q != WAIT_DONE) to_cnt_q <= '0;
      else                      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign timeout_out = to_pulse_q;
`else
  assign to_expire   = 1'b0;
  assign timeout_out = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign cmd_valid_out    = (state_q == ISSUE);
  assign cmd_type_out     = cmd_type_q;
  assign cmd_data_out     = cmd_data_q;
  assign busy_out         = (state_q != IDLE);
  assign pending_out      = pend_q;
  assign coalesce_cnt_out = cnt_q;

endmodule

// File: tb/tb_dds_update_scheduler.sv
// Self-checking bench for dds_update_scheduler: directed scenarios plus a
// randomized run against a behavioural model of the slot/arbiter rules.
// Built with W_CNT = 4 so counter saturation is reachable, TIMEOUT_CYC = 16.
module tb_dds_update_scheduler;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        freq_dv_in = 1'b0;
  logic [47:0] freq_in = '0;
  logic        phase_dv_in = 1'b0;
  logic [13:0] phase_in = '0;
  logic        amp_dv_in = 1'b0;
  logic [9:0]  amp_in = '0;
  logic        cmd_valid_out;
  logic [1:0]  cmd_type_out;
  logic [47:0] cmd_data_out;
  logic        cmd_ready_in = 1'b0;
  logic        wr_done_in = 1'b0;
  logic        busy_out;
  logic [2:0]  pending_out;
  logic [3:0]  coalesce_cnt_out;
  logic        timeout_out;

  int checks = 0;
  int errors = 0;

  dds_update_scheduler #(
    .W_FREQ(48), .W_PHASE(14), .W_AMP(10), .W_CMD(48),
    .W_CNT(4), .TIMEOUT_CYC(16)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .freq_dv_in(freq_dv_in), .freq_in(freq_in),
    .phase_dv_in(phase_dv_in), .phase_in(phase_in),
    .amp_dv_in(amp_dv_in), .amp_in(amp_in),
    .cmd_valid_out(cmd_valid_out), .cmd_type_out(cmd_type_out),
    .cmd_data_out(cmd_data_out), .cmd_ready_in(cmd_ready_in),
    .wr_done_in(wr_done_in), .busy_out(busy_out),
    .pending_out(pending_out), .coalesce_cnt_out(coalesce_cnt_out),
    .timeout_out(timeout_out)
  );

  initial forever #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- behavioural model ----------------
  // phase: 0 = idle, 1 = command offered, 2 = waiting for write-done
  int          m_phase, m_last, m_cnt;
  bit   [2:0]  m_pend;
  logic [47:0] m_val[3];
  logic [1:0]  m_type;
  logic [47:0] m_data;

  task automatic m_reset();
    m_phase = 0; m_last = 2; m_cnt = 0; m_pend = 3'b000;
    for (int t = 0; t < 3; t++) m_val[t] = '0;
    m_type = 2'd0; m_data = '0;
  endtask

  task automatic m_step();
    int g, inc;
    logic [2:0]  s;
    logic [47:0] nv[3];
    logic [47:0] old;
    g = -1; inc = 0; old = '0;
    if (m_phase == 0)
      for (int k = 1; k <= 3; k++) begin
        int j;
        j = (m_last + k) % 3;
        if (g < 0 && m_pend[j]) g = j;
      end
    s = {amp_dv_in, phase_dv_in, freq_dv_in};
    nv[0] = freq_in; nv[1] = {34'd0, phase_in}; nv[2] = {38'd0, amp_in};
    if (g >= 0) old = m_val[g];
    for (int t = 0; t < 3; t++) begin
      if (s[t]) begin
        if (m_pend[t] && g != t) inc++;
        m_val[t] = nv[t];
        m_pend[t] = 1'b1;
      end else if (g == t) m_pend[t] = 1'b0;
    end
    m_cnt = (m_cnt + inc > 15) ? 15 : m_cnt + inc;
    if (g >= 0) begin
      m_type = 2'(g); m_data = old; m_last = g; m_phase = 1;
    end else if (m_phase == 1 && cmd_ready_in) m_phase = 2;
    else if (m_phase == 2 && wr_done_in) m_phase = 0;
  endtask

  // one clock: DUT and model see the same inputs at the edge
  task automatic tick();
    @(posedge clk_in);
    m_step();
    #1;
  endtask

  task automatic do_reset();
    freq_dv_in = 0; phase_dv_in = 0; amp_dv_in = 0;
    cmd_ready_in = 0; wr_done_in = 0;
    rst_in = 0;
    @(posedge clk_in); @(posedge clk_in); #1;
    rst_in = 1;
    m_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (cmd_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", cmd_valid_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_out); end
    checks++; if (pending_out !== 3'b000) begin errors++; $display("FAIL reset_pending got %b want 000", pending_out); end
    checks++; if (coalesce_cnt_out !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", coalesce_cnt_out); end
    checks++; if (cmd_type_out !== 2'd0 || cmd_data_out !== 48'd0) begin errors++; $display("FAIL reset_cmd got %0d/%h want 0/0", cmd_type_out, cmd_data_out); end
    checks++; if (timeout_out !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout_out); end
  endtask

  task automatic test_single_freq();
    do_reset();
    cmd_ready_in = 1;
    freq_dv_in = 1; freq_in = 48'h123456789ABC;
    tick();
    freq_dv_in = 0;
    checks++; if (pending_out !== 3'b001 || cmd_valid_out !== 1'b0) begin errors++; $display("FAIL single_n1 got pend=%b valid=%b want 001/0", pending_out, cmd_valid_out); end
    tick();
    checks++; if (cmd_valid_out !== 1'b1 || cmd_type_out !== 2'd0 || cmd_data_out !== 48'h123456789ABC) begin
      errors++; $display("FAIL single_n2 got v=%b t=%0d d=%h want 1/0/123456789abc", cmd_valid_out, cmd_type_out, cmd_data_out); end
    tick();
    checks++; if (cmd_valid_out !== 1'b0 || busy_out !== 1'b1) begin errors++; $display("FAIL single_accept got v=%b busy=%b want 0/1", cmd_valid_out, busy_out); end
    repeat (3) tick();
    checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL single_wait_busy got %b want 1", busy_out); end
    wr_done_in = 1; tick(); wr_done_in = 0;
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL single_done_busy got %b want 0", busy_out); end
  endtask

  task automatic test_all_three();
    logic [47:0] exp_d[3];
    logic [2:0]  exp_p[3];
    exp_d[0] = 48'h123456789ABC; exp_d[1] = 48'h0ABC; exp_d[2] = 48'h155;
    exp_p[0] = 3'b110; exp_p[1] = 3'b100; exp_p[2] = 3'b000;
    do_reset();
    cmd_ready_in = 1;
    freq_dv_in = 1; phase_dv_in = 1; amp_dv_in = 1;
    freq_in = exp_d[0]; phase_in = 14'h0ABC; amp_in = 10'h155;
    tick();
    freq_dv_in = 0; phase_dv_in = 0; amp_dv_in = 0;
    checks++; if (pending_out !== 3'b111) begin errors++; $display("FAIL all3_pend got %b want 111", pending_out); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (cmd_valid_out !== 1'b1 || cmd_type_out !== 2'(k) || cmd_data_out !== exp_d[k] || pending_out !== exp_p[k]) begin
        errors++; $display("FAIL all3_cmd%0d got v=%b t=%0d d=%h p=%b want 1/%0d/%h/%b", k, cmd_valid_out, cmd_type_out, cmd_data_out, pending_out, k, exp_d[k], exp_p[k]); end
      tick();
      repeat (4) tick();
      wr_done_in = 1; tick(); wr_done_in = 0;
    end
    checks++; if (busy_out !== 1'b0 || coalesce_cnt_out !== 4'd0) begin errors++; $display("FAIL all3_end got busy=%b cnt=%0d want 0/0", busy_out, coalesce_cnt_out); end
  endtask

  task automatic test_coalesce();
    do_reset();
    cmd_ready_in = 1;
    freq_dv_in = 1; freq_in = 48'd1; tick(); freq_dv_in = 0;
    tick(); tick();
    for (int i = 1; i <= 4; i++) begin
      amp_dv_in = 1; amp_in = 10'(i); tick();
      amp_dv_in = 0; tick();
    end
    checks++; if (coalesce_cnt_out !== 4'd3 || pending_out !== 3'b100 || busy_out !== 1'b1) begin
      errors++; $display("FAIL coalesce_cnt got cnt=%0d p=%b busy=%b want 3/100/1", coalesce_cnt_out, pending_out, busy_out); end
    wr_done_in = 1; tick(); wr_done_in = 0;
    tick();
    checks++; if (cmd_valid_out !== 1'b1 || cmd_type_out !== 2'd2 || cmd_data_out !== 48'd4) begin
      errors++; $display("FAIL coalesce_cmd got v=%b t=%0d d=%h want 1/2/4", cmd_valid_out, cmd_type_out, cmd_data_out); end
  endtask

  task automatic test_ready_stall();
    do_reset();
    phase_dv_in = 1; phase_in = 14'h1234; tick(); phase_dv_in = 0;
    tick();
    for (int i = 0; i < 10; i++) begin
      phase_dv_in = (i % 2 == 0); phase_in = 14'($urandom);
      amp_dv_in = (i % 3 == 0); amp_in = 10'($urandom);
      wr_done_in = (i % 2 == 1);
      tick();
      checks++; if (cmd_valid_out !== 1'b1 || cmd_type_out !== 2'd1 || cmd_data_out !== 48'h1234 || busy_out !== 1'b1) begin
        errors++; $display("FAIL stall_%0d got v=%b t=%0d d=%h want 1/1/1234", i, cmd_valid_out, cmd_type_out, cmd_data_out); end
    end
    phase_dv_in = 0; amp_dv_in = 0; wr_done_in = 0; cmd_ready_in = 1;
    tick();
    checks++; if (cmd_valid_out !== 1'b0 || busy_out !== 1'b1) begin errors++; $display("FAIL stall_accept got v=%b busy=%b want 0/1", cmd_valid_out, busy_out); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cmd_ready_in = 1;
    freq_dv_in = 1; freq_in = 48'hABCDEF; tick(); freq_dv_in = 0;
    tick(); tick();
    phase_dv_in = 1; amp_dv_in = 1; tick(); phase_dv_in = 0; amp_dv_in = 0;
    checks++; if (pending_out !== 3'b110 || busy_out !== 1'b1) begin errors++; $display("FAIL rmid_pre got p=%b busy=%b want 110/1", pending_out, busy_out); end
    #2 rst_in = 0;
    #1;
    checks++; if (cmd_valid_out !== 1'b0 || busy_out !== 1'b0 || pending_out !== 3'b000 || cmd_data_out !== 48'd0 || coalesce_cnt_out !== 4'd0) begin
      errors++; $display("FAIL rmid_async got v=%b busy=%b p=%b d=%h want all 0", cmd_valid_out, busy_out, pending_out, cmd_data_out); end
    @(posedge clk_in); #1;
    rst_in = 1;
    m_reset();
    freq_dv_in = 1; phase_dv_in = 1; amp_dv_in = 1; freq_in = 48'h55;
    tick();
    freq_dv_in = 0; phase_dv_in = 0; amp_dv_in = 0;
    tick();
    checks++; if (cmd_valid_out !== 1'b1 || cmd_type_out !== 2'd0 || cmd_data_out !== 48'h55) begin
      errors++; $display("FAIL rmid_first got v=%b t=%0d d=%h want 1/0/55", cmd_valid_out, cmd_type_out, cmd_data_out); end
  endtask

  task automatic test_timeout();
    do_reset();
    cmd_ready_in = 1;
    freq_dv_in = 1; amp_dv_in = 1; amp_in = 10'h2A; tick();
    freq_dv_in = 0; amp_dv_in = 0;
    tick(); tick();
`ifdef DDS_SCHED_TIMEOUT_EN
    begin
      int early = 0;
      for (int k = 1; k <= 15; k++) begin
        tick();
        if (timeout_out !== 1'b0) early++;
      end
      checks++; if (early != 0) begin errors++; $display("FAIL timeout_early got %0d pulses want 0", early); end
      tick();
      checks++; if (timeout_out !== 1'b1 || busy_out !== 1'b0) begin errors++; $display("FAIL timeout_pulse got to=%b busy=%b want 1/0", timeout_out, busy_out); end
      tick();
      checks++; if (timeout_out !== 1'b0 || cmd_valid_out !== 1'b1 || cmd_type_out !== 2'd2 || cmd_data_out !== 48'h2A) begin
        errors++; $display("FAIL timeout_next got to=%b v=%b t=%0d d=%h want 0/1/2/2a", timeout_out, cmd_valid_out, cmd_type_out, cmd_data_out); end
    end
`else
    begin
      int idle_seen = 0;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (busy_out !== 1'b1 || timeout_out !== 1'b0) idle_seen++;
      end
      checks++; if (idle_seen != 0) begin errors++; $display("FAIL no_timeout got %0d cycles not busy want 0", idle_seen); end
    end
`endif
  endtask

  task automatic test_random();
    int wc;
    wc = 0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      freq_dv_in  = ($urandom_range(0, 3) == 0);
      phase_dv_in = ($urandom_range(0, 3) == 0);
      amp_dv_in   = ($urandom_range(0, 3) == 0);
      freq_in  = 48'({$urandom, $urandom});
      phase_in = 14'($urandom);
      amp_in   = 10'($urandom);
      cmd_ready_in = ($urandom_range(0, 2) != 0);
      if (m_phase == 2) begin
        wr_done_in = ($urandom_range(0, 3) == 0) || (wc >= 6);
        wc++;
      end else begin
        wr_done_in = ($urandom_range(0, 7) == 0);
        wc = 0;
      end
      tick();
      checks++; if (cmd_valid_out !== (m_phase == 1)) begin errors++; $display("FAIL rnd_valid c=%0d got %b want %b", c, cmd_valid_out, (m_phase == 1)); end
      checks++; if (busy_out !== (m_phase != 0)) begin errors++; $display("FAIL rnd_busy c=%0d got %b want %b", c, busy_out, (m_phase != 0)); end
      checks++; if (pending_out !== m_pend) begin errors++; $display("FAIL rnd_pend c=%0d got %b want %b", c, pending_out, m_pend); end
      checks++; if (coalesce_cnt_out !== 4'(m_cnt)) begin errors++; $display("FAIL rnd_cnt c=%0d got %0d want %0d", c, coalesce_cnt_out, m_cnt); end
      if (m_phase == 1) begin
        checks++; if (cmd_type_out !== m_type || cmd_data_out !== m_data) begin
          errors++; $display("FAIL rnd_cmd c=%0d got %0d/%h want %0d/%h", c, cmd_type_out, cmd_data_out, m_type, m_data); end
      end
    end
    freq_dv_in = 0; phase_dv_in = 0; amp_dv_in = 0; wr_done_in = 0;
    checks++; if (coalesce_cnt_out !== 4'hF) begin errors++; $display("FAIL rnd_saturate got %0d want 15", coalesce_cnt_out); end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_single_freq();
    test_all_three();
    test_coalesce();
    test_ready_stall();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
